fetch_unit: RTL

- Multicycle instruction fetch stage directly upstream of the main controller/decoder.
- Owns the PC register and issues word reads to instruction memory over a req/ack handshake.
- Holds the fetched instruction stable and drives op/funct to the controller.
- Consumes the controller's pcsrc/jump decisions plus the datapath sign-extended immediate to select the next PC.

---
 rtl/mips_pkg.sv | 14 +
 rtl/fetch_unit_pc_next.sv | 29 ++
 rtl/fetch_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and field constants for the MIPS fetch path.
// Imported by the fetch unit and its next-PC helper.
package mips_pkg;
   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } fetch_state_t;

   localparam int INSTR_W = 32;
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int FUNCT_W = 6;
   localparam int JIDX_W  = 26;
endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: jump, then branch, then pc+4.
// Kept standalone so a later pipelined fetch can reuse it.
module pc_next
   import mips_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_signimm,
   input  logic        i_pcsrc,
   input  logic        i_jump,
   output logic [31:0] o_pcplus4,
   output logic [31:0] o_next_pc
);
   logic [31:0] w_jtarget;
   logic [31:0] w_btarget;

   assign o_pcplus4 = i_pc + 32'd4;
   // the low 26 instruction bits land in [27:2]
   assign w_jtarget = {o_pcplus4[31:28], 28'(i_instr << 2)};
   assign w_btarget = o_pcplus4 + (i_signimm << 2);

   always_comb begin
      o_next_pc = o_pcplus4;
      if (i_jump)
         o_next_pc = w_jtarget;
      else if (i_pcsrc)
         o_next_pc = w_btarget;
   end
endmodule

// File: rtl/fetch_unit.sv
// Multicycle fetch stage: FETCH waits on imem ack, EXEC holds the
// instruction for the controller until it retires.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   input  logic               stall,
   input  logic               pcsrc,
   input  logic               jump,
   input  logic [31:0]        signimm,
   output logic [31:0]        instr,
   output logic               instr_valid,
   output logic [5:0]         op,
   output logic [5:0]         funct,
   output logic [31:0]        pc,
   output logic [31:0]        pcplus4,
   output logic [CNT_W-1:0]   instret
);
   localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

   fetch_state_t       r_state;
   logic [31:0]        r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic [CNT_W-1:0]   r_instret;
   logic [31:0]        w_pcplus4;
   logic [31:0]        w_next_pc;

   pc_next u_pc_next (
      .i_pc      (r_pc),
      .i_instr   (r_instr),
      .i_signimm (signimm),
      .i_pcsrc   (pcsrc),
      .i_jump    (jump),
      .o_pcplus4 (w_pcplus4),
      .o_next_pc (w_next_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= FETCH;
         r_pc      <= PC_INIT;
         r_instr   <= '0;
         r_instret <= '0;
      end else begin
         unique case (r_state)
            FETCH: begin
               if (imem_ack) begin
                  r_instr <= imem_rdata;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (!stall) begin
                  r_pc      <= w_next_pc;
                  r_instret <= r_instret + CNT_W'(1);
                  r_state   <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   assign imem_req    = (r_state == FETCH);
   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == EXEC);
   assign instr       = r_instr;
   assign op          = r_instr[OP_MSB:OP_LSB];
   assign funct       = r_instr[FUNCT_W-1:0];
   assign pc          = r_pc;
   assign pcplus4     = w_pcplus4;
   assign instret     = r_instret;
endmodule
